// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game sequencer: state codes, BCD digit
// width and the default pause length.
package breakout_pkg;

   localparam int DIGIT_W         = 4;
   localparam int DELAY_TICKS_DEF = 120;

   // Codes are visible on state_o and select the text overlay.
   typedef enum logic [2:0] {
      ST_NEWGAME = 3'd0,
      ST_PLAY    = 3'd1,
      ST_NEWBALL = 3'd2,
      ST_OVER    = 3'd3,
      ST_WIN     = 3'd4
   } state_t;

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Link between the game sequencer (master) and the graphics engine (slave).
interface breakout_game_ctrl_if;

   // hit/miss/all_cleared are levels from graphics; gra_still is a level and
   // clear_bricks a 1-clk pulse from the sequencer. No valid/ready handshake.
   logic hit;
   logic miss;
   logic all_cleared;
   logic gra_still;
   logic clear_bricks;

   modport master (
      input  hit, miss, all_cleared,
      output gra_still, clear_bricks
   );

   modport slave (
      output hit, miss, all_cleared,
      input  gra_still, clear_bricks
   );

endinterface

// File: rtl/breakout_score_bcd.sv
// Two-digit BCD score counter that saturates at 99.
module breakout_score_bcd
   import breakout_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] dig1,
   output logic [DIGIT_W-1:0] dig0
);

   logic at_max;

   assign at_max = (dig1 == 4'd9) && (dig0 == 4'd9);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         dig1 <= '0;
         dig0 <= '0;
      end else if (inc && !at_max) begin
         if (dig0 == 4'd9) begin
            dig0 <= '0;
            dig1 <= dig1 + 4'd1;
         end else begin
            dig0 <= dig0 + 4'd1;
         end
      end
   end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: serve/pause/game-over FSM, lives, pause timer and
// BCD score, driving freeze and brick-reset controls for the graphics engine.
module breakout_game_ctrl
   import breakout_pkg::*;
#(
   parameter int BALLS_INIT  = 3,
   parameter int DELAY_TICKS = DELAY_TICKS_DEF,
   parameter int TIMER_W     = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           btn,
   input  logic                 refr_tick,
   breakout_game_ctrl_if.master gfx,
   output logic [2:0]           state_o,
   output logic [1:0]           lives,
   output logic [DIGIT_W-1:0]   dig1,
   output logic [DIGIT_W-1:0]   dig0,
   output logic                 timer_up
);

   localparam logic [1:0]         LIVES_INIT = 2'(BALLS_INIT);
   localparam logic [TIMER_W-1:0] DELAY_LOAD = TIMER_W'(DELAY_TICKS);

   state_t             state, state_next;
   logic [1:0]         lives_next;
   logic [TIMER_W-1:0] timer;
   logic               hit_q, miss_q;
   logic               hit_rise, miss_rise;
   logic               load_timer, clr_score, inc_score, clear_next;
   logic               serve;

   assign hit_rise  = gfx.hit & ~hit_q;
   assign miss_rise = gfx.miss & ~miss_q;
   assign serve     = (btn != 5'd0);
   assign timer_up  = (timer == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_NEWGAME;
         lives            <= LIVES_INIT;
         timer            <= '0;
         hit_q            <= 1'b0;
         miss_q           <= 1'b0;
         gfx.clear_bricks <= 1'b0;
      end else begin
         state            <= state_next;
         lives            <= lives_next;
         hit_q            <= gfx.hit;
         miss_q           <= gfx.miss;
         gfx.clear_bricks <= clear_next;
         if (load_timer)
            timer <= DELAY_LOAD;
         else if (refr_tick && !timer_up)
            timer <= timer - 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      lives_next = lives;
      load_timer = 1'b0;
      clr_score  = 1'b0;
      inc_score  = 1'b0;
      clear_next = 1'b0;
      case (state)
         ST_NEWGAME: begin
            lives_next = LIVES_INIT;
            clr_score  = 1'b1;
            if (serve) begin
               state_next = ST_PLAY;
               clear_next = 1'b1;
            end
         end
         ST_PLAY: begin
            inc_score = hit_rise;
            // A cleared board wins even if the ball is lost in the same clock.
            if (gfx.all_cleared) begin
               state_next = ST_WIN;
               load_timer = 1'b1;
            end else if (miss_rise) begin
               load_timer = 1'b1;
               lives_next = lives - 2'd1;
               state_next = (lives == 2'd1) ? ST_OVER : ST_NEWBALL;
            end
         end
         ST_NEWBALL: begin
            if (timer_up && serve)
               state_next = ST_PLAY;
         end
         ST_OVER, ST_WIN: begin
            if (timer_up)
               state_next = ST_NEWGAME;
         end
         default: state_next = ST_NEWGAME;
      endcase
   end

   assign gfx.gra_still = (state != ST_PLAY);
   assign state_o       = state;

   breakout_score_bcd u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_score),
      .inc   (inc_score),
      .dig1  (dig1),
      .dig0  (dig0)
   );

endmodule
